// File: rtl/oled_pixel_streamer_if.sv
// Pixel-side bus of the OLED streamer: the renderer coordinate/colour bus and the
// panel SPI link, gathered so the streamer and the bench share one definition.
interface oled_pixel_streamer_if;
    logic [6:0]  x;
    logic [5:0]  y;
    logic [15:0] oled_data;
    logic        frame_begin;
    logic        sending_pixels;
    logic        sclk;
    logic        sdin;
    logic        cs_n;
    logic        dc;

    modport master (
        input  oled_data,
        output x, y, frame_begin, sending_pixels, sclk, sdin, cs_n, dc
    );

    modport slave (
        output oled_data,
        input  x, y, frame_begin, sending_pixels, sclk, sdin, cs_n, dc
    );
endinterface

// File: rtl/oled_pixel_streamer.sv
// Scans x/y for the renderers and serialises each returned RGB565 pixel MSB-first over
// mode-0 SPI to the panel. Define OLED_BGR_SWAP_EN to swap the R and B fields.
module oled_pixel_streamer #(
    parameter int WIDTH     = 96,
    parameter int HEIGHT    = 64,
    parameter int CLK_DIV   = 2,
    parameter int PIX_LAT   = 1,
    parameter int FRAME_GAP = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   enable,
    oled_pixel_streamer_if.master  bus
);
    localparam int CNT_MAX = (PIX_LAT > FRAME_GAP) ? PIX_LAT : FRAME_GAP;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    typedef enum logic [2:0] {
        ST_IDLE, ST_START, ST_WAIT, ST_SHIFT, ST_ADV, ST_GAP
    } state_t;

    state_t           state, state_next;
    logic [CNT_W-1:0] cnt;
    logic [DIV_W-1:0] div_cnt;
    logic [4:0]       half_cnt;
    logic [15:0]      shreg;
    logic [6:0]       x_q;
    logic [5:0]       y_q;
    logic             sclk_q, sdin_q;
    logic [15:0]      pix_word;
    logic             wait_done, half_end, shift_done, gap_done, last_col, last_row;
    logic             frame_begin_c, active_c;

`ifdef OLED_BGR_SWAP_EN
    assign pix_word = {bus.oled_data[4:0], bus.oled_data[10:5], bus.oled_data[15:11]};
`else
    assign pix_word = bus.oled_data;
`endif

    assign wait_done  = (cnt == CNT_W'(PIX_LAT - 1));
    assign half_end   = (div_cnt == DIV_W'(CLK_DIV - 1));
    // 32 half-periods make 16 bits; the last one is a high phase
    assign shift_done = half_end && (half_cnt == 5'd31);
    assign gap_done   = (cnt == CNT_W'(FRAME_GAP - 1));
    assign last_col   = (x_q == 7'(WIDTH - 1));
    assign last_row   = (y_q == 6'(HEIGHT - 1));

    // NOTE: every output of this block gets a default first so no path infers a latch.
    always_comb begin
        state_next    = state;
        frame_begin_c = 1'b0;
        active_c      = 1'b0;
        case (state)
            ST_IDLE:  if (enable) state_next = ST_START;
            ST_START: begin
                frame_begin_c = 1'b1;
                active_c      = 1'b1;
                state_next    = ST_WAIT;
            end
            ST_WAIT: begin
                active_c = 1'b1;
                if (wait_done) state_next = ST_SHIFT;
            end
            ST_SHIFT: begin
                active_c = 1'b1;
                if (shift_done) state_next = ST_ADV;
            end
            ST_ADV: begin
                active_c   = 1'b1;
                state_next = (last_col && last_row) ? ST_GAP : ST_WAIT;
            end
            ST_GAP:   if (gap_done) state_next = enable ? ST_START : ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= ST_IDLE;
            cnt      <= '0;
            div_cnt  <= '0;
            half_cnt <= '0;
            shreg    <= '0;
            x_q      <= '0;
            y_q      <= '0;
            sclk_q   <= 1'b0;
            sdin_q   <= 1'b0;
        end else begin
            state <= state_next;
            cnt   <= '0;
            case (state)
                ST_WAIT: begin
                    if (wait_done) begin
                        shreg    <= pix_word;
                        sdin_q   <= pix_word[15];
                        div_cnt  <= '0;
                        half_cnt <= '0;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                ST_SHIFT: begin
                    if (half_end) begin
                        div_cnt  <= '0;
                        half_cnt <= half_cnt + 5'd1;
                        sclk_q   <= ~sclk_q;
                        // data moves only as a high phase ends, i.e. at the start of a low phase
                        if (half_cnt[0]) begin
                            shreg  <= {shreg[14:0], 1'b0};
                            sdin_q <= shreg[14];
                        end
                    end else begin
                        div_cnt <= div_cnt + DIV_W'(1);
                    end
                end
                ST_ADV: begin
                    if (!(last_col && last_row)) begin
                        if (last_col) begin
                            x_q <= '0;
                            y_q <= y_q + 6'd1;
                        end else begin
                            x_q <= x_q + 7'd1;
                        end
                    end
                end
                ST_GAP:  if (!gap_done) cnt <= cnt + CNT_W'(1);
                default: ;
            endcase
            // coordinates hold (WIDTH-1, HEIGHT-1) through the gap and restart at the origin
            if (state_next == ST_START || state_next == ST_IDLE) begin
                x_q <= '0;
                y_q <= '0;
            end
        end
    end

    assign bus.x              = x_q;
    assign bus.y              = y_q;
    assign bus.frame_begin    = frame_begin_c;
    assign bus.sending_pixels = active_c;
    assign bus.cs_n           = ~active_c;
    assign bus.dc             = active_c;
    assign bus.sclk           = sclk_q;
    assign bus.sdin           = sdin_q;
endmodule

// File: tb/tb_oled_pixel_streamer.sv
// Bench for oled_pixel_streamer on a reduced 8x4 raster: a timing model derived from
// frame position checks every output each cycle; an SPI decoder collects the sent words.
module tb_oled_pixel_streamer;
    localparam int W         = 8;
    localparam int H         = 4;
    localparam int CD        = 2;
    localparam int PL        = 1;
    localparam int FG        = 16;
    localparam int P         = PL + 32 * CD + 1;
    localparam int NPIX      = W * H;
    localparam int FRAME_LEN = 1 + NPIX * P;

`ifdef OLED_BGR_SWAP_EN
    localparam logic [15:0] RED_WORD  = 16'h001F;
    localparam logic [15:0] LAST_WORD = 16'hC601;
`else
    localparam logic [15:0] RED_WORD  = 16'hF800;
    localparam logic [15:0] LAST_WORD = 16'h0E18;
`endif

    logic clk = 1'b0;
    logic reset, enable, rmode;
    logic mon_en = 1'b0;
    int   n_tests = 0, n_fail = 0;
    int   fb_cnt = 0;
    bit   m_active = 1'b0;
    int   m_t = 0;
    logic [15:0] words[$];
    logic [15:0] dec_w = '0;
    int   dec_n = 0;

    oled_pixel_streamer_if bus();

    oled_pixel_streamer #(
        .WIDTH(W), .HEIGHT(H), .CLK_DIV(CD), .PIX_LAT(PL), .FRAME_GAP(FG)
    ) dut (
        .clk(clk), .reset(reset), .enable(enable), .bus(bus)
    );

    always #5 clk = ~clk;

    // renderer: either a solid red screen or the coordinates packed into the colour
    assign bus.oled_data = rmode ? {bus.x, bus.y, 3'b000} : 16'hF800;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [15:0] pixel_word(input logic [6:0] px, input logic [5:0] py);
        logic [15:0] raw;
        raw = rmode ? {px, py, 3'b000} : 16'hF800;
`ifdef OLED_BGR_SWAP_EN
        return {raw[4:0], raw[10:5], raw[15:11]};
`else
        return raw;
`endif
    endfunction

    function automatic logic [31:0] pack(input logic fb, input logic [6:0] px, input logic [5:0] py,
                                         input logic sp, input logic sc, input logic sd,
                                         input logic cs, input logic d);
        return {13'b0, fb, px, py, sp, sc, sd, cs, d};
    endfunction

    function automatic logic [31:0] dut_outs();
        return pack(bus.frame_begin, bus.x, bus.y, bus.sending_pixels, bus.sclk, bus.sdin,
                    bus.cs_n, bus.dc);
    endfunction

    // cycle-accurate expectation from the position inside the frame
    always @(negedge clk) begin : model
        int k, o, s;
        logic [6:0]  ex;
        logic [5:0]  ey;
        logic [15:0] w;
        logic [31:0] ev, mask;
        if (mon_en) begin
            mask = 32'h7FFFF;
            if (!m_active) begin
                ev = pack(0, 7'd0, 6'd0, 0, 0, 0, 1, 0);
            end else if (m_t == 0) begin
                ev   = pack(1, 7'd0, 6'd0, 1, 0, 0, 0, 1);
                mask = mask & ~32'h4;
            end else if (m_t < FRAME_LEN) begin
                k  = (m_t - 1) / P;
                o  = (m_t - 1) % P;
                ex = 7'(k % W);
                ey = 6'(k / W);
                if (o >= PL && o < PL + 32 * CD) begin
                    s  = o - PL;
                    w  = pixel_word(ex, ey);
                    ev = pack(0, ex, ey, 1, 1'((s / CD) % 2), w[15 - s / (2 * CD)], 0, 1);
                end else begin
                    ev   = pack(0, ex, ey, 1, 0, 0, 0, 1);
                    mask = mask & ~32'h4;
                end
            end else begin
                ev   = pack(0, 7'(W - 1), 6'(H - 1), 0, 0, 0, 1, 0);
                mask = mask & ~32'h4;
            end
            check("cycle", dut_outs() & mask, ev & mask);
            if (bus.frame_begin === 1'b1) fb_cnt++;

            if (reset) begin
                m_active = 1'b0;
            end else if (!m_active) begin
                if (enable) begin
                    m_active = 1'b1;
                    m_t      = 0;
                end
            end else if (m_t == FRAME_LEN + FG - 1) begin
                if (enable) m_t = 0;
                else        m_active = 1'b0;
            end else begin
                m_t++;
            end
        end
    end

    // SPI receiver: mode 0, MSB first, framing restarts whenever cs_n rises
    always @(posedge bus.sclk or posedge bus.cs_n) begin
        if (bus.cs_n !== 1'b0) begin
            dec_n = 0;
        end else begin
            dec_w = {dec_w[14:0], bus.sdin};
            dec_n++;
            if (dec_n == 16) begin
                words.push_back(dec_w);
                dec_n = 0;
            end
        end
    end

    initial begin
        int n;
        reset  = 1'b1;
        enable = 1'b0;
        rmode  = 1'b0;
        tick();
        mon_en = 1'b1;
        tick();
        check("reset_state", dut_outs(), 32'h2);
        reset = 1'b0;
        tick();

        // solid red: start pulse, first word, per-pixel cost, then drop enable mid-frame
        words.delete();
        fb_cnt = 0;
        enable = 1'b1;
        tick();
        check("t1_frame_begin", {31'b0, bus.frame_begin}, 32'd1);
        check("t1_cs_n_low", {31'b0, bus.cs_n}, 32'd0);
        n = 0;
        while (n < 200) begin
            tick();
            if (bus.x != 7'd0) break;
            n++;
        end
        check("t1_first_pixel_cycles", n, 66);
        n = 0;
        while (words.size() < 1 && n < 200) begin tick(); n++; end
        check("t1_word_timeout", {31'b0, n < 200}, 32'd1);
        if (words.size() > 0) check("t1_first_word", {16'b0, words[0]}, {16'b0, RED_WORD});
        n = 0;
        while (bus.y != 6'd2 && n < 3000) begin tick(); n++; end
        enable = 1'b0;
        n = 0;
        while (bus.cs_n !== 1'b1 && n < 3000) begin tick(); n++; end
        check("t4_frame_end_timeout", {31'b0, n < 3000}, 32'd1);
        repeat (300) tick();
        check("t4_words_sent", words.size(), NPIX);
        check("t4_single_frame_begin", fb_cnt, 1);

        // coordinate renderer across two back-to-back frames
        words.delete();
        fb_cnt = 0;
        rmode  = 1'b1;
        enable = 1'b1;
        n = 0;
        while (bus.frame_begin !== 1'b1 && n < 10) begin tick(); n++; end
        tick();
        n = 0;
        while (bus.cs_n !== 1'b1 && n < 3000) begin tick(); n++; end
        check("t2_frame_timeout", {31'b0, n < 3000}, 32'd1);
        check("t2_word_count", words.size(), NPIX);
        if (words.size() >= NPIX) begin
            check("t2_word_0_0", {16'b0, words[0]}, 32'h0000);
            check("t2_word_1_0", {16'b0, words[1]}, 32'h0200);
            check("t2_word_last", {16'b0, words[NPIX-1]}, {16'b0, LAST_WORD});
        end
        n = 0;
        while (bus.cs_n === 1'b1 && n < 100) begin n++; tick(); end
        check("t3_gap_cycles", n, FG);
        check("t3_second_frame_begin", {31'b0, bus.frame_begin}, 32'd1);
        enable = 1'b0;
        tick();
        n = 0;
        while (bus.cs_n !== 1'b1 && n < 3000) begin tick(); n++; end
        repeat (50) tick();
        check("t3_two_frames_words", words.size(), 2 * NPIX);
        check("t3_frame_begin_count", fb_cnt, 2);

        // reset in the middle of pixel 20's shift, then a clean restart
        words.delete();
        enable = 1'b1;
        n = 0;
        while (!(bus.x == 7'd4 && bus.y == 6'd2 && bus.sclk === 1'b1) && n < 3000) begin
            tick();
            n++;
        end
        check("t5_reach_shift", {31'b0, n < 3000}, 32'd1);
        reset  = 1'b1;
        enable = 1'b0;
        tick();
        check("t5_reset_abort", {19'b0, bus.cs_n, bus.sclk, bus.x, bus.y, bus.sending_pixels},
              {19'b0, 1'b1, 1'b0, 7'd0, 6'd0, 1'b0});
        reset = 1'b0;
        tick();
        words.delete();
        enable = 1'b1;
        tick();
        check("t5_restart_begin", {18'b0, bus.frame_begin, bus.x, bus.y}, {18'b0, 1'b1, 13'd0});
        n = 0;
        while (words.size() < 1 && n < 200) begin tick(); n++; end
        check("t5_restart_word", {15'b0, n < 200, (words.size() > 0) ? words[0] : 16'hFFFF},
              {15'b0, 1'b1, 16'h0000});
        enable = 1'b0;
        n = 0;
        while (bus.cs_n !== 1'b1 && n < 3000) begin tick(); n++; end
        repeat (30) tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
